// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead byte FIFO and serializes each byte as an
// asynchronous UART frame (start, 8 data bits LSB first, optional parity,
// one or two stop bits). One byte is popped per frame. The pop is issued
// only from IDLE, so consecutive frames are separated by one idle cycle.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic              PAR_ON    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity of a byte; odd sense inverts the XOR reduction.
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t            state_r, state_s;
  logic [BAUD_W-1:0] baud_r, baud_s;
  logic [2:0]        bit_r, bit_s;
  logic [7:0]        shift_r, shift_s;
  logic              par_r, par_s;
  logic              tx_r, tx_s;
  logic              busy_r;
  logic [15:0]       frame_count_r;
  logic              pop_s;
  logic              baud_end_s;
  logic              count_inc_s;

  // Next-state, next-tx and pop decode; tx is computed for the next cycle so
  // the registered line shows each bit exactly in its own bit period.
  always_comb begin
    pop_s       = rst_n & (state_r == IDLE) & tx_enable & ~fifo_empty;
    baud_end_s  = (baud_r == BAUD_LAST);
    state_s     = state_r;
    baud_s      = baud_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    par_s       = par_r;
    tx_s        = tx_r;
    count_inc_s = 1'b0;
    case (state_r)
      IDLE: begin
        tx_s   = 1'b1;
        baud_s = BAUD_ZERO;
        bit_s  = 3'd0;
        if (pop_s) begin
          state_s = START;
          shift_s = fifo_data;
          par_s   = parity_of(fifo_data, PAR_ODD);
          tx_s    = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          state_s = DATA;
          baud_s  = BAUD_ZERO;
          bit_s   = 3'd0;
          tx_s    = shift_r[0];
        end else begin
          baud_s = baud_r + BAUD_ONE;
          tx_s   = 1'b0;
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_s = BAUD_ZERO;
          if (bit_r == 3'd7) begin
            bit_s = 3'd0;
            if (PAR_ON) begin
              state_s = PARITY;
              tx_s    = par_r;
            end else begin
              state_s = STOP;
              tx_s    = 1'b1;
            end
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      PARITY: begin
        if (baud_end_s) begin
          state_s = STOP;
          baud_s  = BAUD_ZERO;
          bit_s   = 3'd0;
          tx_s    = 1'b1;
        end else begin
          baud_s = baud_r + BAUD_ONE;
          tx_s   = par_r;
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (baud_end_s) begin
          baud_s = BAUD_ZERO;
          if (bit_r == STOP_LAST) begin
            state_s     = IDLE;
            bit_s       = 3'd0;
            count_inc_s = 1'b1;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = BAUD_ZERO;
        bit_s   = 3'd0;
        tx_s    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and forces tx high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      baud_r  <= BAUD_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Completed-frame counter; bumps on the edge leaving STOP, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_r <= 16'h0000;
    end else if (count_inc_s) begin
      frame_count_r <= frame_count_r + 16'h0001;
    end
  end

  assign fifo_rd_en  = pop_s;
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one 8N1 instance plus two parity
// instances (even/2 stop, odd/1 stop), all at 4 clocks per bit.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_enable;
  logic        fe0, fe1, fe2;
  logic [7:0]  fd0, fd1, fd2;
  logic        rd0, rd1, rd2;
  logic        tx0, tx1, tx2;
  logic        busy0, busy1, busy2;
  logic [15:0] cnt0, cnt1, cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fe0), .fifo_data(fd0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .frame_count(cnt0));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_pe (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fe1), .fifo_data(fd1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_count(cnt1));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fe2), .fifo_data(fd2),
    .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .frame_count(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int s);
    case (s)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic rd_of(input int s);
    case (s)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  // Wait (bounded) at negedges for a pop strobe; checks it came after exp_n cycles.
  task automatic wait_pop(input int s, input int limit, input int exp_n, input string tag);
    int n = 0;
    while (rd_of(s) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_pop"}, {31'd0, rd_of(s)}, 32'd1);
    chk({tag, "_wait"}, n, exp_n);
  endtask

  // Called at the negedge just after the pop edge; checks every cycle of the
  // frame and returns at the negedge of the following idle cycle.
  task automatic frame(input int s, input logic [7:0] b, input int par_en,
                       input logic par_bit, input int nstop, input string tag);
    int   nb;
    logic e;
    nb = 1 + 8 + par_en + nstop;
    for (int k = 0; k < nb; k++) begin
      if (k == 0) e = 1'b0;
      else if (k < 9) e = b[k-1];
      else if (k == 9 && par_en != 0) e = par_bit;
      else e = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("%s_tx_b%0d_c%0d", tag, k, c), {31'd0, tx_of(s)}, {31'd0, e});
        chk($sformatf("%s_busy_b%0d", tag, k), {31'd0, busy_of(s)}, 32'd1);
        chk($sformatf("%s_nopop_b%0d", tag, k), {31'd0, rd_of(s)}, 32'd0);
        @(negedge clk);
      end
    end
    chk({tag, "_busy_end"}, {31'd0, busy_of(s)}, 32'd0);
    chk({tag, "_tx_end"}, {31'd0, tx_of(s)}, 32'd1);
  endtask

  initial begin
    logic bad;
    rst_n     = 1'b0;
    tx_enable = 1'b1;
    fe0 = 1'b0; fd0 = 8'hA5;
    fe1 = 1'b1; fd1 = 8'h00;
    fe2 = 1'b1; fd2 = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state, with a pop otherwise pending.
    chk("rst_tx", {31'd0, tx0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_cnt", {16'd0, cnt0}, 32'd0);
    chk("rst_rd", {31'd0, rd0}, 32'd0);

    // Single byte 0xA5.
    rst_n = 1'b1;
    #1;
    wait_pop(0, 2, 0, "a5");
    @(negedge clk);
    fe0 = 1'b1;
    frame(0, 8'hA5, 0, 1'b0, 1, "a5");
    chk("a5_cnt", {16'd0, cnt0}, 32'd1);

    // Empty FIFO for 100 cycles: no pop, line idle.
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rd0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("empty_idle", {31'd0, bad}, 32'd0);

    // Back-to-back 0x00, 0xFF, 0x3C: pops 41 cycles apart.
    fe0 = 1'b0; fd0 = 8'h00;
    #1;
    wait_pop(0, 2, 0, "b00");
    @(negedge clk);
    fd0 = 8'hFF;
    frame(0, 8'h00, 0, 1'b0, 1, "b00");
    wait_pop(0, 0, 0, "bff");
    @(negedge clk);
    fd0 = 8'h3C;
    frame(0, 8'hFF, 0, 1'b0, 1, "bff");
    wait_pop(0, 0, 0, "b3c");
    @(negedge clk);
    fe0 = 1'b1;
    frame(0, 8'h3C, 0, 1'b0, 1, "b3c");
    chk("b2b_cnt", {16'd0, cnt0}, 32'd4);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rd0 !== 1'b0 || tx0 !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    chk("b2b_drained", {31'd0, bad}, 32'd0);

    // tx_enable dropped mid-frame; FIFO data changes while busy.
    fe0 = 1'b0; fd0 = 8'h5A;
    #1;
    wait_pop(0, 2, 0, "en5a");
    @(negedge clk);
    fd0 = 8'hC3;
    tx_enable = 1'b0;
    frame(0, 8'h5A, 0, 1'b0, 1, "en5a");
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rd0 !== 1'b0 || busy0 !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("dis_nopop", {31'd0, bad}, 32'd0);
    tx_enable = 1'b1;
    #1;
    wait_pop(0, 1, 0, "enc3");
    @(negedge clk);
    fe0 = 1'b1;
    frame(0, 8'hC3, 0, 1'b0, 1, "enc3");
    chk("en_cnt", {16'd0, cnt0}, 32'd6);

    // Reset during data bit 3 of 0x96 (bit 3 is 0).
    fe0 = 1'b0; fd0 = 8'h96;
    #1;
    wait_pop(0, 2, 0, "r96");
    @(negedge clk);
    repeat (17) @(negedge clk);
    chk("mid_tx_bit3", {31'd0, tx0}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, tx0}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt0}, 32'd0);
    chk("mid_rst_rd", {31'd0, rd0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_pop(0, 2, 0, "post");
    @(negedge clk);
    fe0 = 1'b1;
    frame(0, 8'h96, 0, 1'b0, 1, "post");
    chk("post_cnt", {16'd0, cnt0}, 32'd1);

    // Even parity, 2 stop bits, 0x07 -> parity 1, 48-cycle frame.
    fe1 = 1'b0; fd1 = 8'h07;
    #1;
    wait_pop(1, 2, 0, "pe");
    @(negedge clk);
    fe1 = 1'b1;
    frame(1, 8'h07, 1, 1'b1, 2, "pe");
    chk("pe_cnt", {16'd0, cnt1}, 32'd1);

    // Odd parity, 1 stop bit, 0x07 -> parity 0.
    fe2 = 1'b0; fd2 = 8'h07;
    #1;
    wait_pop(2, 2, 0, "po");
    @(negedge clk);
    fe2 = 1'b1;
    frame(2, 8'h07, 1, 1'b0, 1, "po");
    chk("po_cnt", {16'd0, cnt2}, 32'd1);

    // Counter wrap: preload 0xFFFF, one more frame gives 0x0000.
    force dut.frame_count_r = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_r;
    #1;
    chk("wrap_preload", {16'd0, cnt0}, 32'h0000FFFF);
    fe0 = 1'b0; fd0 = 8'h81;
    #1;
    wait_pop(0, 2, 0, "wrap");
    @(negedge clk);
    fe0 = 1'b1;
    frame(0, 8'h81, 0, 1'b0, 1, "wrap");
    chk("wrap_cnt", {16'd0, cnt0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
